// File: rtl/sipo_word_collector.sv
// Serial-in, parallel-out word collector. Assembles WIDTH qualified serial bits into a word
// and offers it on a valid/ready handshake, flagging overrun when a completed word is dropped.
module sipo_word_collector #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     d_in,
    input  logic                     d_en,
    output logic [WIDTH-1:0]         word_out,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic                     overrun,
    output logic [$clog2(WIDTH)-1:0] bit_cnt
);

    localparam int unsigned CntW = $clog2(WIDTH);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;

    logic [WIDTH-1:0] shifted;
    logic             complete;

    assign shifted  = MSB_FIRST ? {shift_q[WIDTH-2:0], d_in} : {d_in, shift_q[WIDTH-1:1]};
    assign complete = d_en && (cnt_q == CntW'(WIDTH - 1));

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;

        if (clr) begin
            shift_d = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end else begin
            if (valid_q && word_ready) begin
                valid_d = 1'b0;
            end
            if (d_en) begin
                shift_d = shifted;
                cnt_d   = complete ? '0 : cnt_q + CntW'(1);
            end
            // A completed word is only deliverable if the output slot is free or draining now.
            if (complete) begin
                if (!valid_q || word_ready) begin
                    word_d  = shifted;
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign overrun    = ovr_q;
    assign bit_cnt    = cnt_q;

endmodule

// File: tb/tb_sipo_word_collector.sv
// Bench for sipo_word_collector: MSB-first and LSB-first instances share stimulus and are
// compared against a queue-based model of the word assembly and handshake rules.
module tb_sipo_word_collector;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic       d_in = 1'b0;
    logic       d_en = 1'b0;
    logic       word_ready = 1'b0;

    logic [7:0] word_m, word_l;
    logic       valid_m, valid_l, ovr_m, ovr_l;
    logic [2:0] cnt_m, cnt_l;

    int tests = 0;
    int fails = 0;

    // Model state
    bit         q_bits[$];
    logic [7:0] e_word_m = '0;
    logic [7:0] e_word_l = '0;
    bit         e_valid = 1'b0;
    bit         e_ovr = 1'b0;

    always #5 clk = ~clk;

    sipo_word_collector #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .d_in       (d_in),
        .d_en       (d_en),
        .word_out   (word_m),
        .word_valid (valid_m),
        .word_ready (word_ready),
        .overrun    (ovr_m),
        .bit_cnt    (cnt_m)
    );

    sipo_word_collector #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .d_in       (d_in),
        .d_en       (d_en),
        .word_out   (word_l),
        .word_valid (valid_l),
        .word_ready (word_ready),
        .overrun    (ovr_l),
        .bit_cnt    (cnt_l)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".word_m"},  32'(word_m),  32'(e_word_m));
        check({tag, ".word_l"},  32'(word_l),  32'(e_word_l));
        check({tag, ".valid_m"}, 32'(valid_m), 32'(e_valid));
        check({tag, ".valid_l"}, 32'(valid_l), 32'(e_valid));
        check({tag, ".ovr_m"},   32'(ovr_m),   32'(e_ovr));
        check({tag, ".ovr_l"},   32'(ovr_l),   32'(e_ovr));
        check({tag, ".cnt_m"},   32'(cnt_m),   32'(q_bits.size()));
        check({tag, ".cnt_l"},   32'(cnt_l),   32'(q_bits.size()));
    endtask

    task automatic model_reset();
        q_bits.delete();
        e_word_m = '0;
        e_word_l = '0;
        e_valid  = 1'b0;
        e_ovr    = 1'b0;
    endtask

    // Apply one cycle of inputs, advance the model across the edge, then compare.
    task automatic step(input bit din, input bit den, input bit rdy, input bit cl,
                        input string tag);
        logic [7:0] wm, wl;
        bit         slot_free;
        d_in = din;
        d_en = den;
        word_ready = rdy;
        clr = cl;
        @(posedge clk);
        slot_free = !e_valid || rdy;
        if (cl) begin
            q_bits.delete();
            e_valid = 1'b0;
            e_ovr   = 1'b0;
        end else begin
            if (e_valid && rdy) e_valid = 1'b0;
            if (den) begin
                q_bits.push_back(din);
                if (q_bits.size() == 8) begin
                    wm = '0;
                    wl = '0;
                    for (int i = 0; i < 8; i++) begin
                        wm[7-i] = q_bits[i];
                        wl[i]   = q_bits[i];
                    end
                    q_bits.delete();
                    if (slot_free) begin
                        e_word_m = wm;
                        e_word_l = wl;
                        e_valid  = 1'b1;
                    end else begin
                        e_ovr = 1'b1;
                    end
                end
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic send_word(input logic [7:0] w, input bit rdy_rest, input bit rdy_last,
                             input string tag);
        logic [7:0] v;
        v = w;
        for (int i = 7; i >= 0; i--) begin
            step(v[i], 1'b1, (i == 0) ? rdy_last : rdy_rest, 1'b0, tag);
        end
    endtask

    initial begin
        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check_all("reset");
        rst = 1'b1;

        // Back-to-back bits, downstream ready
        send_word(8'hB2, 1'b1, 1'b1, "b2");
        check("b2_msb_const", 32'(word_m), 32'h000000B2);
        check("b2_lsb_const", 32'(word_l), 32'h0000004D);
        check("b2_valid", 32'(valid_m), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0, "b2_drain");
        check("b2_valid_one_cycle", 32'(valid_m), 32'd0);

        // Same word with one-cycle gaps between bits
        begin
            logic [7:0] v;
            v = 8'hB2;
            for (int i = 7; i >= 0; i--) begin
                step(v[i], 1'b1, 1'b1, 1'b0, "gap_bit");
                if (i != 0) step(1'b1, 1'b0, 1'b1, 1'b0, "gap_idle");
            end
        end
        check("gap_const", 32'(word_m), 32'h000000B2);
        check("gap_valid", 32'(valid_m), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0, "gap_drain");

        // Overrun: two words with no ready
        send_word(8'hB2, 1'b0, 1'b0, "ovr_w1");
        send_word(8'hFF, 1'b0, 1'b0, "ovr_w2");
        check("ovr_word_kept", 32'(word_m), 32'h000000B2);
        check("ovr_flag", 32'(ovr_m), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0, "ovr_accept");
        check("ovr_sticky", 32'(ovr_m), 32'd1);
        check("ovr_valid_low", 32'(valid_m), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b1, "clr");
        check("clr_ovr", 32'(ovr_m), 32'd0);

        // Transfer coincides with completion
        send_word(8'hB2, 1'b0, 1'b0, "hold_b2");
        send_word(8'h5A, 1'b0, 1'b1, "coinc");
        check("coinc_word", 32'(word_m), 32'h0000005A);
        check("coinc_valid", 32'(valid_m), 32'd1);
        check("coinc_ovr", 32'(ovr_m), 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, "coinc_drain");

        // Asynchronous reset mid-word
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0, "pre_rst");
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #2;
        rst = 1'b1;
        send_word(8'hC3, 1'b1, 1'b1, "c3");
        check("c3_const", 32'(word_m), 32'h000000C3);
        step(1'b0, 1'b0, 1'b1, 1'b0, "c3_drain");

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 59) == 0), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
